cpu_controller: RTL

// - Control unit for the 16-bit single-issue processor: owns the PC and the IR.
// - Fetches from a synchronous instruction ROM, decodes, and sequences Datapath

---
 rtl/cpu_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cpu_controller.sv
// ============================================================================
// Module      : cpu_controller
// Description : Multi-cycle control unit for the 16-bit processor. Owns PC and
//               IR, fetches from a registered instruction ROM and sequences
//               Datapath controls. Optional macro: CPU_CTRL_STEP_EN (step gate).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_controller #(
  parameter int PC_W     = 7,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
`ifdef CPU_CTRL_STEP_EN
  input  logic            step,
`endif
  input  logic [15:0]     instr_in,
  output logic [PC_W-1:0] pc_out,
  output logic [15:0]     ir_out,
  output logic [3:0]      state_out,
  output logic            halted,
  output logic [7:0]      D_Addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [2:0]      Alu_s0
);

  localparam logic [3:0] S_INIT    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_LOAD_IR = 4'd2;
  localparam logic [3:0] S_DECODE  = 4'd3;
  localparam logic [3:0] S_NOOP    = 4'd4;
  localparam logic [3:0] S_STORE   = 4'd5;
  localparam logic [3:0] S_LOAD_A  = 4'd6;
  localparam logic [3:0] S_LOAD_B  = 4'd7;
  localparam logic [3:0] S_ADD     = 4'd8;
  localparam logic [3:0] S_SUB     = 4'd9;
  localparam logic [3:0] S_HALT    = 4'd10;

  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;

  logic [3:0]      state;
  logic [3:0]      state_next;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic            fetch_go;

`ifdef CPU_CTRL_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  // State, PC and IR registers; IR capture and PC increment share LOAD_IR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
      pc    <= PC_W'(RESET_PC);
      ir    <= 16'h0000;
    end else begin
      state <= state_next;
      if (state == S_LOAD_IR) begin
        ir <= instr_in;
        pc <= pc + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:    state_next = S_FETCH;
      S_FETCH:   state_next = fetch_go ? S_LOAD_IR : S_FETCH;
      S_LOAD_IR: state_next = S_DECODE;
      S_DECODE: begin
        case (ir[15:12])
          OP_STORE: state_next = S_STORE;
          OP_LOAD:  state_next = S_LOAD_A;
          OP_ADD:   state_next = S_ADD;
          OP_SUB:   state_next = S_SUB;
          OP_HALT:  state_next = S_HALT;
          default:  state_next = S_NOOP;
        endcase
      end
      S_NOOP:    state_next = S_FETCH;
      S_STORE:   state_next = S_FETCH;
      S_LOAD_A:  state_next = S_LOAD_B;
      S_LOAD_B:  state_next = S_FETCH;
      S_ADD:     state_next = S_FETCH;
      S_SUB:     state_next = S_FETCH;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_INIT;
    endcase
  end

  // Moore outputs decoded from state and IR only.
  always_comb begin
    D_Addr     = 8'h00;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'h0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'h0;
    RF_Rb_addr = 4'h0;
    Alu_s0     = 3'b000;
    case (state)
      S_STORE: begin
        D_Addr     = ir[7:0];
        RF_Ra_addr = ir[11:8];
        D_wr       = 1'b1;
      end
      S_LOAD_A: begin
        D_Addr = ir[11:4];
        RF_s   = 1'b1;
      end
      S_LOAD_B: begin
        D_Addr    = ir[11:4];
        RF_s      = 1'b1;
        RF_W_addr = ir[3:0];
        RF_W_en   = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir[11:8];
        RF_Rb_addr = ir[7:4];
        RF_W_addr  = ir[3:0];
        RF_W_en    = 1'b1;
        Alu_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: begin
      end
    endcase
  end

  assign pc_out    = pc;
  assign ir_out    = ir;
  assign state_out = state;
  assign halted    = (state == S_HALT);

endmodule

`default_nettype wire
